hilo_muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer that owns the HI/LO registers of the MIPS core.
//  - Decodes the CU multiply/divide/HI_sel/LO_sel/MultoRF fields into operations.
//  - Runs a shared radix-2 engine for mult/multu/div/divu/mul.
//  - Serves mthi/mtlo/mfhi/mflo, and interlocks the pipeline with stall.

---
 rtl/hilo_muldiv_seq_pkg.sv | 8 +
 rtl/hilo_muldiv_seq_if.sv | 11 +
 rtl/hilo_muldiv_seq_step.sv | 19 +
 rtl/hilo_muldiv_seq.sv | 104 ++++++++++
 tb/tb_hilo_muldiv_seq.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_seq_pkg.sv
// hilo_muldiv_seq_pkg: shared encodings for the HI/LO multiply/divide sequencer
package hilo_muldiv_seq_pkg;
    localparam logic [1:0] SEL_MT   = 2'b00;
    localparam logic [1:0] SEL_MULT = 2'b01;
    localparam logic [1:0] RF_MUL   = 2'd1;
    typedef enum logic [1:0] {OP_MULT, OP_MUL, OP_DIV} op_e;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// hilo_muldiv_seq_if: decode-stage request and HI/LO result bundle
interface hilo_muldiv_seq_if #(parameter int WIDTH = 32);
    logic             issue_valid;
    logic [1:0]       multiply, divide, HI_sel, LO_sel, MultoRF;
    logic [WIDTH-1:0] rs_val, rt_val, rf_data, hi, lo;
    logic             stall, busy, div_zero;
    modport master (output issue_valid, multiply, divide, HI_sel, LO_sel, MultoRF, rs_val, rt_val,
                    input stall, busy, rf_data, div_zero, hi, lo);
    modport slave  (input issue_valid, multiply, divide, HI_sel, LO_sel, MultoRF, rs_val, rt_val,
                    output stall, busy, rf_data, div_zero, hi, lo);
endinterface

// File: rtl/hilo_muldiv_seq_step.sv
// hilo_muldiv_seq_step: one radix-2 iteration on {acc,q}, shift-add or restoring subtract
module hilo_muldiv_seq_step #(parameter int WIDTH = 32) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] q_n
);
    logic [WIDTH:0] sum, shl, diff;
    // acc stays below b while dividing, so diff's top bit is a clean borrow flag
    always_comb begin
        sum   = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
        shl   = {acc, q[WIDTH-1]};
        diff  = shl - {1'b0, b};
        acc_n = div_mode ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        q_n   = div_mode ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
    end
endmodule

// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: iterative mult/div sequencer owning HI/LO with pipeline interlock
module hilo_muldiv_seq
    import hilo_muldiv_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit DZ_FAST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    hilo_muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, mul_res_q, mul_res_d;
    logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, mul_ready_q, mul_ready_d;
    logic [WIDTH-1:0] acc_s, q_s, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic             is_mult, is_mul, is_div, is_mthi, is_mtlo, is_mf, sgn, start;

    hilo_muldiv_seq_step #(.WIDTH(WIDTH)) u_step (
        .div_mode(op_q == OP_DIV), .acc(acc_q), .q(q_q), .b(b_q), .acc_n(acc_s), .q_n(q_s)
    );

    // decode the CU fields and derive the interlock and register-file read data
    always_comb begin
        is_mul       = bus.issue_valid & bus.multiply[1] & (bus.MultoRF == RF_MUL);
        is_mult      = bus.issue_valid & bus.multiply[1] & (bus.HI_sel == SEL_MULT) & ~is_mul;
        is_div       = bus.issue_valid & bus.divide[1];
        is_mthi      = bus.issue_valid & (bus.HI_sel == SEL_MT);
        is_mtlo      = bus.issue_valid & (bus.LO_sel == SEL_MT);
        is_mf        = bus.issue_valid & bus.MultoRF[1];
        sgn          = is_div ? bus.divide[0] : bus.multiply[0];
        start        = (state_q == IDLE) & (is_mult | is_div | (is_mul & ~mul_ready_q));
        bus.busy     = state_q != IDLE;
        bus.stall    = bus.busy ? (is_mult | is_div | is_mul | is_mthi | is_mtlo | is_mf)
                                : (is_mul & ~mul_ready_q);
        bus.rf_data  = bus.busy ? '0 : (is_mul & mul_ready_q) ? mul_res_q :
                       is_mf ? (bus.MultoRF[0] ? lo_q : hi_q) : '0;
        bus.div_zero = (state_q == FIX) & (op_q == OP_DIV) & dz_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end

    // FSM next state; with rt==0 the sign of b is 0, so quo also rebuilds the raw dividend
    always_comb begin
        state_d = state_q; op_d = op_q; cnt_d = cnt_q; acc_d = acc_q; q_d = q_q; b_d = b_q;
        sa_d = sa_q; sb_d = sb_q; dz_d = dz_q; hi_d = hi_q; lo_d = lo_q;
        mul_res_d = mul_res_q; mul_ready_d = mul_ready_q;
        prod = (sa_q ^ sb_q) ? -{acc_q, q_q} : {acc_q, q_q};
        quo  = (sa_q ^ sb_q) ? -q_q : q_q;
        rem  = sa_q ? -acc_q : acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = is_div ? OP_DIV : is_mul ? OP_MUL : OP_MULT;
                    sa_d    = sgn & bus.rs_val[WIDTH-1];
                    sb_d    = sgn & bus.rt_val[WIDTH-1];
                    q_d     = sa_d ? -bus.rs_val : bus.rs_val;
                    b_d     = sb_d ? -bus.rt_val : bus.rt_val;
                    acc_d   = '0;
                    cnt_d   = '0;
                    dz_d    = is_div & (bus.rt_val == '0);
                    state_d = (dz_d && DZ_FAST) ? FIX : RUN;
                end else begin
                    hi_d        = is_mthi ? bus.rs_val : hi_q;
                    lo_d        = is_mtlo ? bus.rs_val : lo_q;
                    mul_ready_d = mul_ready_q & ~is_mul;
                end
            end
            RUN: begin
                acc_d   = dz_q ? acc_q : acc_s;
                q_d     = dz_q ? q_q : q_s;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            default: begin
                state_d = IDLE;
                if (op_q == OP_MULT) {hi_d, lo_d} = prod;
                else if (op_q == OP_MUL) begin
                    mul_res_d   = prod[WIDTH-1:0];
                    mul_ready_d = 1'b1;
                end else begin
                    lo_d = dz_q ? '1 : quo;
                    hi_d = dz_q ? quo : rem;
                end
            end
        endcase
    end

    // state, operand and HI/LO registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE; op_q <= OP_MULT; cnt_q <= '0; acc_q <= '0; q_q <= '0; b_q <= '0;
            sa_q <= 1'b0; sb_q <= 1'b0; dz_q <= 1'b0; hi_q <= '0; lo_q <= '0;
            mul_res_q <= '0; mul_ready_q <= 1'b0;
        end else begin
            state_q <= state_d; op_q <= op_d; cnt_q <= cnt_d; acc_q <= acc_d; q_q <= q_d; b_q <= b_d;
            sa_q <= sa_d; sb_q <= sb_d; dz_q <= dz_d; hi_q <= hi_d; lo_q <= lo_d;
            mul_res_q <= mul_res_d; mul_ready_q <= mul_ready_d;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb_hilo_muldiv_seq: directed self-checking bench for the HI/LO mult/div sequencer
module tb_hilo_muldiv_seq;
    localparam int W = 32;
    logic clk, rst;
    int checks = 0, errors = 0;

    hilo_muldiv_seq_if #(.WIDTH(W)) bus ();
    hilo_muldiv_seq #(.WIDTH(W), .DZ_FAST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] mu, dv, hs, ls, mrf, input logic [31:0] a, b);
        bus.issue_valid = v; bus.multiply = mu; bus.divide = dv; bus.HI_sel = hs;
        bus.LO_sel = ls; bus.MultoRF = mrf; bus.rs_val = a; bus.rt_val = b;
    endtask
    task automatic nop();                                        drive(0, 0, 0, 3, 3, 0, 0, 0); endtask
    task automatic op_mult(input logic s, input logic [31:0] a, b); drive(1, {1'b1, s}, 0, 1, 1, 0, a, b); endtask
    task automatic op_div(input logic s, input logic [31:0] a, b);  drive(1, 0, {1'b1, s}, 2, 2, 0, a, b); endtask
    task automatic op_mul(input logic [31:0] a, b);                 drive(1, 3, 0, 3, 3, 1, a, b); endtask
    task automatic op_mf(input logic from_hi);                      drive(1, 0, 0, 3, 3, from_hi ? 2'd2 : 2'd3, 0, 0); endtask
    task automatic op_mthi(input logic [31:0] a);                   drive(1, 0, 0, 0, 3, 0, a, 0); endtask
    task automatic op_mtlo(input logic [31:0] a);                   drive(1, 0, 0, 3, 0, 0, a, 0); endtask

    task automatic test_reset();
        rst = 1'b1; nop();
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({bus.busy, bus.stall, bus.div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.stall, bus.div_zero}); end
        checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo}); end
        checks++; if (bus.rf_data !== 32'h0) begin errors++; $display("FAIL reset_rf: got %h expected 0", bus.rf_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult_mflo();
        op_mult(1, 32'hFFFFFFFD, 32'd7);
        #1; checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mult_issue_stall: got %b expected 0", bus.stall); end
        @(negedge clk); op_mf(0);
        for (int i = 0; i < W + 1; i++) begin
            #1; checks++; if ({bus.stall, bus.busy} !== 2'b11) begin errors++; $display("FAIL mflo_interlock cyc %0d: got %b expected 11", i + 1, {bus.stall, bus.busy}); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mflo_release: got %b expected 0", bus.stall); end
        checks++; if (bus.rf_data !== 32'hFFFFFFEB) begin errors++; $display("FAIL mflo_data: got %h expected ffffffeb", bus.rf_data); end
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
        nop(); @(negedge clk);
    endtask

    task automatic test_multu();
        op_mult(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk); nop();
        repeat (W) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL multu_busy_last: got %b expected 1", bus.busy); end
        checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL multu_lo_early: got %h expected ffffffeb", bus.lo); end
        @(negedge clk); #1;
        checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_result: got %h expected fffffffe00000001", {bus.hi, bus.lo}); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_div();
        logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] a  [4] = '{32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000};
        logic [31:0] b  [4] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] ql [4] = '{32'hFFFFFFFD, 32'd3, 32'hFFFFFFFD, 32'h80000000};
        logic [31:0] rh [4] = '{32'hFFFFFFFF, 32'd1, 32'd1, 32'd0};
        for (int i = 0; i < 4; i++) begin
            op_div(sg[i], a[i], b[i]);
            @(negedge clk); nop();
            repeat (W + 1) @(negedge clk);
            #1;
            checks++; if (bus.lo !== ql[i]) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, bus.lo, ql[i]); end
            checks++; if (bus.hi !== rh[i]) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, bus.hi, rh[i]); end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] a [2] = '{32'd5, 32'hFFFFFFFB};
        for (int i = 0; i < 2; i++) begin
            op_div(1, a[i], 32'd0);
            @(negedge clk); nop(); #1;
            checks++; if ({bus.div_zero, bus.busy} !== 2'b11) begin errors++; $display("FAIL dz%0d_pulse: got %b expected 11", i, {bus.div_zero, bus.busy}); end
            @(negedge clk); #1;
            checks++; if ({bus.div_zero, bus.busy} !== 2'b00) begin errors++; $display("FAIL dz%0d_end: got %b expected 00", i, {bus.div_zero, bus.busy}); end
            checks++; if ({bus.hi, bus.lo} !== {a[i], 32'hFFFFFFFF}) begin errors++; $display("FAIL dz%0d_hilo: got %h expected %h", i, {bus.hi, bus.lo}, {a[i], 32'hFFFFFFFF}); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] a [2] = '{32'd6, 32'hFFFFFFFA};
        logic [31:0] r [2] = '{32'd42, 32'hFFFFFFD6};
        for (int i = 0; i < 2; i++) begin
            op_mul(a[i], 32'd7);
            #1; checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mul%0d_issue_stall: got %b expected 1", i, bus.stall); end
            for (int c = 0; c < W + 1; c++) begin
                @(negedge clk); #1;
                checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mul%0d_stall cyc %0d: got %b expected 1", i, c + 1, bus.stall); end
            end
            @(negedge clk); #1;
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mul%0d_release: got %b expected 0", i, bus.stall); end
            checks++; if (bus.rf_data !== r[i]) begin errors++; $display("FAIL mul%0d_data: got %h expected %h", i, bus.rf_data, r[i]); end
            checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFB_FFFFFFFF) begin errors++; $display("FAIL mul%0d_hilo_kept: got %h expected fffffffbffffffff", i, {bus.hi, bus.lo}); end
            @(negedge clk); nop(); #1;
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul%0d_no_restart: got %b expected 0", i, bus.busy); end
        end
    endtask

    task automatic test_mt_mf();
        op_mthi(32'h1234);
        @(negedge clk); op_mtlo(32'h5678); #1;
        checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h expected 1234", bus.hi); end
        @(negedge clk); op_mf(1); #1;
        checks++; if ({bus.stall, bus.rf_data} !== {1'b0, 32'h1234}) begin errors++; $display("FAIL mfhi: got %h expected 0_00001234", {bus.stall, bus.rf_data}); end
        op_mf(0); #1;
        checks++; if (bus.rf_data !== 32'h5678) begin errors++; $display("FAIL mflo: got %h expected 5678", bus.rf_data); end
        @(negedge clk); nop();
    endtask

    task automatic test_back_to_back();
        op_mult(1, 32'd3, 32'd4);
        @(negedge clk); op_div(0, 32'd100, 32'd7);
        for (int i = 0; i < W + 1; i++) begin
            #1; checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall cyc %0d: got %b expected 1", i + 1, bus.stall); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %b expected 0", bus.stall); end
        checks++; if ({bus.hi, bus.lo} !== 64'h0_0000000C) begin errors++; $display("FAIL b2b_mult: got %h expected 000000000000000c", {bus.hi, bus.lo}); end
        @(negedge clk); nop();
        repeat (W + 1) @(negedge clk);
        #1;
        checks++; if ({bus.hi, bus.lo} !== 64'h00000002_0000000E) begin errors++; $display("FAIL b2b_div: got %h expected 000000020000000e", {bus.hi, bus.lo}); end
    endtask

    task automatic test_rst_mid();
        op_mthi(32'h1234);
        @(negedge clk); op_div(1, 32'd100, 32'd3); #1;
        checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL rst_pre_hi: got %h expected 1234", bus.hi); end
        @(negedge clk); nop();
        repeat (5) @(negedge clk);
        #1; checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", bus.busy); end
        rst = 1'b1; #1;
        checks++; if ({bus.busy, bus.hi, bus.lo} !== 65'h0) begin errors++; $display("FAIL rst_mid: got %h expected 0", {bus.busy, bus.hi, bus.lo}); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); op_mf(1); #1;
        checks++; if (bus.rf_data !== 32'h0) begin errors++; $display("FAIL rst_mfhi: got %h expected 0", bus.rf_data); end
        @(negedge clk); nop(); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b expected 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_mult_mflo();
        test_multu();
        test_div();
        test_div_zero();
        test_mul();
        test_mt_mf();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
